// File: rtl/arb2_client.sv
// rtl/arb2_client.sv - requester-side agent for the two-way arb2 arbiter
module arb2_client #(
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = 16,
    parameter int STV_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             gnt,
    output logic             req,
    output logic             beat,
    output logic [LEN_W-1:0] beat_cnt,
    output logic             done,
    output logic             starve
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REL    = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               pend_valid;
    logic [LEN_W-1:0]   pend_len;
    logic [LEN_W-1:0]   cur_len;
    logic [STV_W-1:0]   stv_cnt;
    logic               load;

    assign job_ready = !pend_valid;
    assign beat      = req && gnt;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load    = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat && (beat_cnt + LEN_W'(1) == cur_len)) begin
                    state_n = REL;
                end
            end
            REL:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            req   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            req   <= (state_n == ACTIVE);
            done  <= (state_n == REL);
        end
    end

    // The slot only empties on a load, so accept and load never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_len   <= '0;
        end else if (load) begin
            pend_valid <= 1'b0;
        end else if (job_valid && job_ready) begin
            pend_valid <= 1'b1;
            pend_len   <= (job_len == '0) ? LEN_W'(1) : job_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            cur_len  <= pend_len;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    // Starve is sticky across REL; only a real beat (or reset) clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stv_cnt <= '0;
            starve  <= 1'b0;
        end else begin
            if (beat || state != ACTIVE) begin
                stv_cnt <= '0;
            end else if (req && !gnt && stv_cnt != STV_W'(STARVE_MAX)) begin
                stv_cnt <= stv_cnt + STV_W'(1);
            end
            if (beat) begin
                starve <= 1'b0;
            end else if (state == ACTIVE && req && !gnt
                         && stv_cnt == STV_W'(STARVE_MAX - 1)) begin
                starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb2_client.sv
// tb/tb_arb2_client.sv - directed self-checking bench for arb2_client
module tb_arb2_client;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             gnt;
    logic             req;
    logic             beat;
    logic [LEN_W-1:0] beat_cnt;
    logic             done;
    logic             starve;

    int checks   = 0;
    int failures = 0;

    arb2_client #(.LEN_W(LEN_W), .STARVE_MAX(16), .STV_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .gnt       (gnt),
        .req       (req),
        .beat      (beat),
        .beat_cnt  (beat_cnt),
        .done      (done),
        .starve    (starve)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sets gnt for the current cycle, then checks req/beat/beat_cnt/done.
    task automatic cyc(input string tag, input logic g, input logic e_req,
                       input logic [LEN_W-1:0] e_cnt, input logic e_done);
        gnt = g;
        #1;
        chk({tag, ".req"},  req,      e_req);
        chk({tag, ".beat"}, beat,     e_req && g);
        chk({tag, ".cnt"},  beat_cnt, e_cnt);
        chk({tag, ".done"}, done,     e_done);
        tick;
    endtask

    task automatic offer(input logic [LEN_W-1:0] len);
        job_valid = 1'b1;
        job_len   = len;
        #1;
        chk("offer.ready", job_ready, 1'b1);
        tick;
        job_valid = 1'b0;
    endtask

    logic [5:0] pre_pat;
    logic [LEN_W-1:0] pre_cnt;

    initial begin
        rst = 1'b0; job_valid = 1'b0; job_len = '0; gnt = 1'b0;
        tick;
        chk("rst.req",    req,       1'b0);
        chk("rst.ready",  job_ready, 1'b1);
        chk("rst.cnt",    beat_cnt,  0);
        chk("rst.done",   done,      1'b0);
        chk("rst.starve", starve,    1'b0);
        rst = 1'b1;
        tick;
        cyc("idle_gnt", 1'b1, 1'b0, 0, 1'b0);
        cyc("idle_gnt2", 1'b1, 1'b0, 0, 1'b0);

        // single burst of 3, gnt held high
        offer(3);
        cyc("sb.load", 1'b0, 1'b0, 0, 1'b0);
        cyc("sb.b1", 1'b1, 1'b1, 0, 1'b0);
        cyc("sb.b2", 1'b1, 1'b1, 1, 1'b0);
        cyc("sb.b3", 1'b1, 1'b1, 2, 1'b0);
        cyc("sb.rel", 1'b1, 1'b0, 3, 1'b1);
        cyc("sb.idle", 1'b0, 1'b0, 3, 1'b0);

        // preemption: len 4, gnt 1,0,0,1,1,1
        pre_pat = 6'b111001;
        pre_cnt = 0;
        offer(4);
        cyc("pre.load", 1'b0, 1'b0, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc("pre.act", pre_pat[i], 1'b1, pre_cnt, 1'b0);
            if (pre_pat[i]) pre_cnt = pre_cnt + 1;
        end
        cyc("pre.rel", 1'b0, 1'b0, 4, 1'b1);
        cyc("pre.idle", 1'b0, 1'b0, 4, 1'b0);

        // back-to-back: A len 2, B len 1 offered while A is pending/active
        offer(2);
        job_valid = 1'b1; job_len = 1;
        #1; chk("b2b.ready_full", job_ready, 1'b0);
        cyc("b2b.loadA", 1'b0, 1'b0, 4, 1'b0);
        #1; chk("b2b.ready_free", job_ready, 1'b1);
        cyc("b2b.a1", 1'b1, 1'b1, 0, 1'b0);
        job_valid = 1'b0;
        #1; chk("b2b.ready_B", job_ready, 1'b0);
        cyc("b2b.a2", 1'b1, 1'b1, 1, 1'b0);
        cyc("b2b.relA", 1'b1, 1'b0, 2, 1'b1);
        cyc("b2b.gap2", 1'b1, 1'b0, 2, 1'b0);
        cyc("b2b.b1", 1'b1, 1'b1, 0, 1'b0);
        cyc("b2b.relB", 1'b0, 1'b0, 1, 1'b1);
        cyc("b2b.idle", 1'b0, 1'b0, 1, 1'b0);

        // starvation: 16 waiting cycles set starve on the 16th edge
        offer(1);
        cyc("stv.load", 1'b0, 1'b0, 1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #1; chk("stv.pre", starve, 1'b0);
            cyc("stv.wait", 1'b0, 1'b1, 0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            #1; chk("stv.set", starve, 1'b1);
            cyc("stv.hold", 1'b0, 1'b1, 0, 1'b0);
        end
        cyc("stv.beat", 1'b1, 1'b1, 0, 1'b0);
        chk("stv.clear", starve, 1'b0);
        cyc("stv.rel", 1'b0, 1'b0, 1, 1'b1);

        // reset mid-burst
        tick;
        offer(5);
        cyc("mid.load", 1'b0, 1'b0, 1, 1'b0);
        cyc("mid.b1", 1'b1, 1'b1, 0, 1'b0);
        cyc("mid.b2", 1'b1, 1'b1, 1, 1'b0);
        gnt = 1'b1;
        #1; chk("mid.cnt2", beat_cnt, 2);
        rst = 1'b0;
        #1;
        chk("mid.req",   req,       1'b0);
        chk("mid.beat",  beat,      1'b0);
        chk("mid.cnt",   beat_cnt,  0);
        chk("mid.ready", job_ready, 1'b1);
        tick;
        rst = 1'b1;
        cyc("mid.after", 1'b0, 1'b0, 0, 1'b0);
        cyc("mid.after2", 1'b1, 1'b0, 0, 1'b0);
        offer(1);
        cyc("mid.nload", 1'b0, 1'b0, 0, 1'b0);
        cyc("mid.nb1", 1'b1, 1'b1, 0, 1'b0);
        cyc("mid.nrel", 1'b0, 1'b0, 1, 1'b1);

        // zero length behaves as one beat
        offer(0);
        cyc("zl.load", 1'b0, 1'b0, 1, 1'b0);
        cyc("zl.b1", 1'b1, 1'b1, 0, 1'b0);
        cyc("zl.rel", 1'b1, 1'b0, 1, 1'b1);
        cyc("zl.idle", 1'b1, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb2_client.md
Name: arb2_client

Overview:
- Requester-side agent for the two-way `arb2` arbiter. It is the other end of the req/gnt handshake.
- Accepts burst jobs from local logic, raises `req`, and counts granted beats until the burst completes, then releases the bus.
- Flags starvation when `req` waits too long without a grant.
- Two instances, one per arbiter port, form the client side of the arbitration subsystem.

Parameters:
- LEN_W, 4, width of burst length and beat counter.
- STARVE_MAX, 16, consecutive req-without-gnt cycles that set `starve`.
- STV_W, 5, width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- job_valid  input  1  local job offer.
- job_len  input  LEN_W  beats requested; 0 is treated as 1.
- job_ready  output  1  pending slot empty; a job is accepted when job_valid && job_ready.
- gnt  input  1  grant from arbiter (`gnt1` or `gnt2`).
- req  output  1  request to arbiter (registered).
- beat  output  1  combinational, req && gnt: one data beat transferred this cycle.
- beat_cnt  output  LEN_W  beats completed in current job (registered).
- done  output  1  one-cycle pulse after the last beat of a job.
- starve  output  1  sticky starvation flag.

Behaviour:
- Reset (rst=0, async): req=0, done=0, starve=0, beat_cnt=0, starvation counter=0, pending slot empty (job_ready=1), state IDLE.
- Pending slot: one-entry buffer.
  - job_ready = !pend_valid.
  - An accepted job stores job_len, mapping 0 to 1.
  - The slot is independent of the FSM, so a job can be queued while a burst runs.
- FSM:
  - IDLE: if pend_valid, load cur_len, clear pend_valid, beat_cnt<=0, go ACTIVE; req=1 from the next cycle. A job accepted in cycle N sets req in cycle N+2: slot in N+1, load N+1, req visible N+2.
  - ACTIVE: req=1.
    - Each cycle with gnt=1 is a beat, and beat_cnt increments.
    - gnt low mid-burst (preemption): beat_cnt holds and req stays high.
    - On the beat where beat_cnt+1 == cur_len: go REL; req=0 and done=1 in the following cycle.
  - REL: req=0 for exactly one cycle (mandatory release gap); done=1 this cycle; go IDLE.
    - beat_cnt holds the final count until the next job loads.
    - A job already pending leaves IDLE the next cycle, so the minimum req-low gap between back-to-back jobs is 2 cycles (REL, IDLE).
- gnt while req=0 (IDLE/REL) is ignored: no beat, no count.
- Starvation:
  - The counter increments on every cycle with req=1 && gnt=0, saturating at STARVE_MAX.
  - It clears on any beat or on leaving ACTIVE.
  - starve<=1 when the counter reaches STARVE_MAX.
  - starve clears only on the next beat or on reset; it is not cleared by REL without a beat.
- Length arithmetic:
  - beat_cnt never exceeds cur_len.
  - Maximum burst is 2^LEN_W-1 beats, 15 by default; no wrap.
- Reset mid-burst: immediate req=0, job lost, pending slot cleared, no done pulse.
- Simultaneous accept and load in IDLE with an empty slot: the job enters the slot first, so loading happens the cycle after acceptance. There is no bypass.

Test Plan:
- Reset then idle: rst=0 for 1 cycle, then 1 → req=0, job_ready=1, beat_cnt=0, done=0, starve=0. gnt=1 while idle → beat=0.
- Single burst, gnt always 1: job_len=3 accepted at cycle 0 → req high cycles 2–4, beat on 3 cycles, beat_cnt 1,2,3, req=0 and done=1 at cycle 5, beat_cnt stays 3.
- Preemption: job_len=4, gnt pattern 1,0,0,1,1,1 → beat_cnt 1,1,1,2,3,4, req stays high throughout, then REL with done pulse. Exactly 4 beats.
- Back-to-back:
  - Offer job A (len 2), then job B (len 1) while A is active → job_ready drops after B is accepted.
  - req low for exactly 2 cycles between A and B.
  - Two done pulses total.
- Starvation: job_len=1, gnt=0 for 16 cycles → starve=1 on cycle 16 of waiting and remains 1. gnt=1 → beat, starve=0, done follows.
- Reset mid-burst: job_len=5, 2 beats, then rst=0 → req=0 asynchronously, beat_cnt=0, no done. After release, job_ready=1 and a new len=1 job completes normally.
- job_len=0 → treated as 1 beat, single done pulse.
